// File: rtl/fft_input_buffer.sv
// Ping-pong serial-to-parallel buffer: gathers N complex samples into a frame
// while the other bank is held for the butterfly stage.
module fft_input_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_imag,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_real,
  output logic [N*DATA_W-1:0] out_imag,
  output logic                overflow
);

  localparam int unsigned CNT_W = $clog2(N);

  logic [1:0]       bank_full;
  logic [1:0]       bank_full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_cnt;

  logic [DATA_W-1:0] mem_real [2][N];
  logic [DATA_W-1:0] mem_imag [2][N];

  logic accept;
  logic last;
  logic transfer;

  assign in_ready  = ~bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign accept    = in_valid & in_ready;
  assign last      = (wr_cnt == CNT_W'(N - 1));
  assign transfer  = out_valid & out_ready;

  // Completion and transfer always target different banks, so both apply.
  always_comb begin
    bank_full_nxt = bank_full;
    if (transfer)
      bank_full_nxt[rd_bank] = 1'b0;
    if (accept && last)
      bank_full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      overflow  <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (in_valid && !in_ready)
        overflow <= 1'b1;
      if (accept) begin
        wr_cnt <= last ? '0 : wr_cnt + CNT_W'(1);
        if (last)
          wr_bank <= ~wr_bank;
      end
      if (transfer)
        rd_bank <= ~rd_bank;
    end
  end

  // Sample storage needs no reset: it is only visible once a bank is FULL.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_real[wr_bank][wr_cnt] <= in_real;
      mem_imag[wr_bank][wr_cnt] <= in_imag;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign out_real[k*DATA_W +: DATA_W] = out_valid ? mem_real[rd_bank][k] : '0;
    assign out_imag[k*DATA_W +: DATA_W] = out_valid ? mem_imag[rd_bank][k] : '0;
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed bench for fft_input_buffer: a vector table for the basic frame,
// then hand-written sequences for backpressure, overflow, gaps and reset.
module tb_fft_input_buffer;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 16;
  localparam int unsigned FW = DW * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_real;
  logic [FW-1:0] out_imag;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  fft_input_buffer #(.DATA_W(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic          out_ready;
    logic          exp_ready;
    logic          exp_valid;
    logic          exp_ovf;
    logic [FW-1:0] exp_real;
    logic [FW-1:0] exp_imag;
  } vec_t;

  vec_t tbl [18];

  // Frame whose slot k holds base+k (or its two's-complement negation).
  function automatic logic [FW-1:0] ramp(input int base, input bit neg);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < int'(N); k++)
      f[k*DW +: DW] = neg ? DW'(-(base + k)) : DW'(base + k);
    return f;
  endfunction

  function automatic logic [FW-1:0] const_frame(input logic [DW-1:0] v);
    logic [FW-1:0] f;
    for (int k = 0; k < int'(N); k++)
      f[k*DW +: DW] = v;
    return f;
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [DW-1:0] re,
                              input logic [DW-1:0] im, input logic ordy, input logic erdy,
                              input logic evld, input logic eovf,
                              input logic [FW-1:0] efr, input logic [FW-1:0] efi);
    vec_t x;
    x.rst = r; x.in_valid = v; x.in_real = re; x.in_imag = im; x.out_ready = ordy;
    x.exp_ready = erdy; x.exp_valid = evld; x.exp_ovf = eovf;
    x.exp_real = efr; x.exp_imag = efi;
    return x;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkf(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic r, input logic v, input logic [DW-1:0] re,
                       input logic [DW-1:0] im, input logic ordy);
    rst = r; in_valid = v; in_real = re; in_imag = im; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic erdy, input logic evld,
                              input logic eovf, input logic [FW-1:0] efr,
                              input logic [FW-1:0] efi);
    chk1({tag, "_in_ready"}, in_ready, erdy);
    chk1({tag, "_out_valid"}, out_valid, evld);
    chk1({tag, "_overflow"}, overflow, eovf);
    chkf({tag, "_out_real"}, out_real, efr);
    chkf({tag, "_out_imag"}, out_imag, efi);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b0;

    // Basic frame: reset, 16 samples real=k imag=-k, consumer always ready.
    tbl[0] = mk(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 16; k++)
      tbl[k+1] = mk(1'b0, 1'b1, DW'(k), DW'(-k), 1'b1, 1'b1, (k == 15), 1'b0,
                    (k == 15) ? ramp(0, 1'b0) : '0, (k == 15) ? ramp(0, 1'b1) : '0);
    tbl[17] = mk(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].in_valid, tbl[i].in_real, tbl[i].in_imag, tbl[i].out_ready);
      expect_state($sformatf("t1_v%0d", i), tbl[i].exp_ready, tbl[i].exp_valid,
                   tbl[i].exp_ovf, tbl[i].exp_real, tbl[i].exp_imag);
    end

    // Backpressure: 32 samples fill both banks, frame 1 held stable.
    for (int v = 0; v < 32; v++) begin
      drive(1'b0, 1'b1, DW'(v), DW'(-v), 1'b0);
      expect_state($sformatf("t2_s%0d", v), (v < 31), (v >= 15), 1'b0,
                   (v >= 15) ? ramp(0, 1'b0) : '0, (v >= 15) ? ramp(0, 1'b1) : '0);
    end
    drive(1'b0, 1'b1, DW'(99), DW'(99), 1'b0);
    expect_state("t2_drop", 1'b0, 1'b1, 1'b1, ramp(0, 1'b0), ramp(0, 1'b1));

    // One-cycle out_ready pulse swaps to frame 2 and frees a bank.
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    expect_state("t3_pulse", 1'b1, 1'b1, 1'b1, ramp(16, 1'b0), ramp(16, 1'b1));
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    expect_state("t3_hold", 1'b1, 1'b1, 1'b1, ramp(16, 1'b0), ramp(16, 1'b1));
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    expect_state("t3_drain", 1'b1, 1'b0, 1'b1, '0, '0);

    // Gaps between every accept; gap data must never be stored.
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b1, DW'(100 + a), DW'(-(100 + a)), 1'b0);
      expect_state($sformatf("t4_acc%0d", a), 1'b1, (a == 15), 1'b1,
                   (a == 15) ? ramp(100, 1'b0) : '0, (a == 15) ? ramp(100, 1'b1) : '0);
      drive(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b0);
      expect_state($sformatf("t4_gap%0d", a), 1'b1, (a == 15), 1'b1,
                   (a == 15) ? ramp(100, 1'b0) : '0, (a == 15) ? ramp(100, 1'b1) : '0);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    expect_state("t4_drain", 1'b1, 1'b0, 1'b1, '0, '0);

    // Reset mid-frame discards the partial frame and clears overflow.
    for (int a = 0; a < 9; a++) begin
      drive(1'b0, 1'b1, DW'(16'h5500 + a), DW'(16'h6600 + a), 1'b1);
      expect_state($sformatf("t5_pre%0d", a), 1'b1, 1'b0, 1'b1, '0, '0);
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    expect_state("t5_rst", 1'b1, 1'b0, 1'b0, '0, '0);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0);
      expect_state($sformatf("t5_s%0d", a), 1'b1, (a == 15), 1'b0,
                   (a == 15) ? const_frame(16'h1234) : '0,
                   (a == 15) ? const_frame(16'h1234) : '0);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    expect_state("t5_drain", 1'b1, 1'b0, 1'b0, '0, '0);

    // Streaming: 100 frames back-to-back with the consumer always ready.
    for (int i = 0; i < 1600; i++) begin
      drive(1'b0, 1'b1, DW'(i), DW'(-i), 1'b1);
      expect_state($sformatf("t6_c%0d", i), 1'b1, (i % 16 == 15), 1'b0,
                   (i % 16 == 15) ? ramp(i - 15, 1'b0) : '0,
                   (i % 16 == 15) ? ramp(i - 15, 1'b1) : '0);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    expect_state("t6_end", 1'b1, 1'b0, 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
